gb_cpu_mcycle_sequencer: RTL and testbench

Parametrised M-cycle sequencer for the Game Boy CPU core. It steps through a decoded per-instruction control schedule one M-cycle at a time and emits the control word for each cycle. Beyond plain sequencing, it handles four things: bus stalls, early termination on a failed condition, HALT, and interrupt dispatch. It sits between the decoder (which supplies the schedule) and the datapath (which consumes the control word).

---
 rtl/gb_cpu_common_pkg.sv | 38 +++
 rtl/gb_cpu_mcycle_sequencer_if.sv | 39 +++
 rtl/gb_cpu_seq_ctrl_mux.sv | 44 ++++
 rtl/gb_cpu_mcycle_sequencer.sv | 135 +++++++++++++
 tb/tb_gb_cpu_mcycle_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: control word layout, sequencer state encoding and default schedule constants.
package gb_cpu_common_pkg;

  localparam int unsigned SEQ_MAX_STEPS = 6;
  localparam int unsigned SEQ_IRQ_STEPS = 5;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2,
    IRQ   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [3:0]  reg_src_a;
    logic [3:0]  reg_src_b;
    logic [3:0]  reg_dst;
    logic [2:0]  addr_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        pc_inc;
    logic        pc_load;
    logic        sp_inc;
    logic        sp_dec;
    logic        ir_load;
    logic [3:0]  flag_we;
    logic [1:0]  imm_sel;
    logic [30:0] reserved;
  } control_signals_t;

  // Opcode fetch: read [PC] into IR and advance PC (addr_sel 0 selects PC).
  localparam control_signals_t SEQ_FETCH_CTRL = '{mem_rd: 1'b1, pc_inc: 1'b1, ir_load: 1'b1, default: '0};

  // HALT cycle: no bus access, no register or flag writes.
  localparam control_signals_t SEQ_IDLE_CTRL = '{default: '0};

endpackage

// File: rtl/gb_cpu_mcycle_sequencer_if.sv
// Decoder/interrupt-side inputs and datapath-side outputs of the M-cycle sequencer.
interface gb_cpu_mcycle_sequencer_if #(
  parameter int unsigned MAX_STEPS = 6,
  parameter int unsigned CTRL_W    = 64,
  parameter int unsigned IRQ_STEPS = 5
);
  localparam int unsigned STEP_MAX = (MAX_STEPS > IRQ_STEPS) ? MAX_STEPS : IRQ_STEPS;
  localparam int unsigned STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam int unsigned LEN_W    = $clog2(MAX_STEPS + 1);

  logic [MAX_STEPS*CTRL_W-1:0] sched_ctrl;
  logic [LEN_W-1:0]            sched_len;
  logic                        sched_cb_prefix;
  logic                        sched_halt;
  logic [IRQ_STEPS*CTRL_W-1:0] irq_ctrl;
  logic                        cond_not_met;
  logic                        stall;
  logic                        irq_pending;
  logic                        ime;
  logic [CTRL_W-1:0]           control_next;
  logic [1:0]                  state;
  logic [STEP_W-1:0]           step;
  logic                        cb_prefix_o;
  logic                        instr_done;
  logic                        irq_ack;
  logic                        illegal_o;

  modport master (
    output sched_ctrl, sched_len, sched_cb_prefix, sched_halt, irq_ctrl,
           cond_not_met, stall, irq_pending, ime,
    input  control_next, state, step, cb_prefix_o, instr_done, irq_ack, illegal_o
  );

  modport slave (
    input  sched_ctrl, sched_len, sched_cb_prefix, sched_halt, irq_ctrl,
           cond_not_met, stall, irq_pending, ime,
    output control_next, state, step, cb_prefix_o, instr_done, irq_ack, illegal_o
  );
endinterface

// File: rtl/gb_cpu_seq_ctrl_mux.sv
// Combinational selection of the current M-cycle control word.
module gb_cpu_seq_ctrl_mux
  import gb_cpu_common_pkg::*;
#(
  parameter int unsigned      MAX_STEPS  = 6,
  parameter int unsigned      CTRL_W     = 64,
  parameter int unsigned      IRQ_STEPS  = 5,
  parameter int unsigned      STEP_W     = 3,
  parameter logic [CTRL_W-1:0] FETCH_CTRL = '0,
  parameter logic [CTRL_W-1:0] IDLE_CTRL  = '0
) (
  input  logic [1:0]                  state,
  input  logic [STEP_W-1:0]           step,
  input  logic [MAX_STEPS*CTRL_W-1:0] sched_ctrl,
  input  logic [IRQ_STEPS*CTRL_W-1:0] irq_ctrl,
  output logic [CTRL_W-1:0]           control_next
);

  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_HALT  = HALT;
  localparam logic [1:0] S_IRQ   = IRQ;

  // Pick the fixed word for FETCH/HALT, or the step-indexed schedule word for EXEC/IRQ.
  always_comb begin
    control_next = FETCH_CTRL;
    case (state)
      S_FETCH: control_next = FETCH_CTRL;
      S_HALT:  control_next = IDLE_CTRL;
      S_EXEC: begin
        control_next = '0;
        for (int k = 0; k < int'(MAX_STEPS); k++)
          if (step == STEP_W'(k)) control_next = sched_ctrl[k*CTRL_W +: CTRL_W];
      end
      S_IRQ: begin
        control_next = '0;
        for (int k = 0; k < int'(IRQ_STEPS); k++)
          if (step == STEP_W'(k)) control_next = irq_ctrl[k*CTRL_W +: CTRL_W];
      end
      default: control_next = FETCH_CTRL;
    endcase
  end

endmodule

// File: rtl/gb_cpu_mcycle_sequencer.sv
// Steps through a decoded per-instruction schedule, handling stalls, early exit, HALT and IRQ dispatch.
module gb_cpu_mcycle_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter int unsigned       MAX_STEPS  = SEQ_MAX_STEPS,
  parameter int unsigned       CTRL_W     = 64,
  parameter int unsigned       IRQ_STEPS  = SEQ_IRQ_STEPS,
  parameter logic [CTRL_W-1:0] FETCH_CTRL = '0,
  parameter logic [CTRL_W-1:0] IDLE_CTRL  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  gb_cpu_mcycle_sequencer_if.slave bus
);

  localparam int unsigned STEP_MAX = (MAX_STEPS > IRQ_STEPS) ? MAX_STEPS : IRQ_STEPS;
  localparam int unsigned STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam int unsigned LEN_W    = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_HALT  = HALT;
  localparam logic [1:0] S_IRQ   = IRQ;

  logic [1:0]        state_q, state_d, mux_state;
  logic [STEP_W-1:0] step_q, step_d;
  logic              cb_q, cb_d;
  logic              ill_q, ill_d;
  logic              len_bad, last_exec, last_irq;
  logic [LEN_W-1:0]  eff_len;
  logic              done_c, ack_c;
  logic [CTRL_W-1:0] ctrl_sel;

  // Out-of-range schedule lengths collapse to a single execute cycle.
  always_comb begin
    len_bad   = (bus.sched_len == '0) || (bus.sched_len > LEN_W'(MAX_STEPS));
    eff_len   = len_bad ? LEN_W'(1) : bus.sched_len;
    last_exec = (step_q == STEP_W'(eff_len - LEN_W'(1))) || bus.cond_not_met;
    last_irq  = (step_q == STEP_W'(IRQ_STEPS - 1));
  end

  // Next-state, step and flag logic; stall holds everything and masks the pulses.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cb_d    = cb_q;
    ill_d   = ill_q;
    done_c  = 1'b0;
    ack_c   = 1'b0;
    if (!bus.stall) begin
      case (state_q)
        S_FETCH: begin
          state_d = S_EXEC;
          step_d  = '0;
        end
        S_EXEC: begin
          ill_d = ill_q | len_bad;
          if (last_exec) begin
            done_c = 1'b1;
            step_d = '0;
            cb_d   = bus.sched_cb_prefix & ~bus.cond_not_met;
            if (bus.sched_halt)                                         state_d = S_HALT;
            else if (bus.ime && bus.irq_pending && !bus.sched_cb_prefix) state_d = S_IRQ;
            else                                                        state_d = S_FETCH;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        S_HALT: begin
          if (bus.irq_pending) begin
            state_d = bus.ime ? S_IRQ : S_FETCH;
            step_d  = '0;
          end
        end
        S_IRQ: begin
          ack_c = (step_q == '0);
          if (last_irq) begin
            done_c  = 1'b1;
            state_d = S_FETCH;
            step_d  = '0;
            cb_d    = 1'b0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        default: begin
          state_d = S_FETCH;
          step_d  = '0;
        end
      endcase
    end
  end

  // State, step and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      step_q  <= '0;
      cb_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cb_q    <= cb_d;
      ill_q   <= ill_d;
    end
  end

  // While reset is held the datapath sees a fetch word and no pulses.
  assign mux_state = reset ? S_FETCH : state_q;

  gb_cpu_seq_ctrl_mux #(
    .MAX_STEPS  (MAX_STEPS),
    .CTRL_W     (CTRL_W),
    .IRQ_STEPS  (IRQ_STEPS),
    .STEP_W     (STEP_W),
    .FETCH_CTRL (FETCH_CTRL),
    .IDLE_CTRL  (IDLE_CTRL)
  ) u_ctrl_mux (
    .state        (mux_state),
    .step         (step_q),
    .sched_ctrl   (bus.sched_ctrl),
    .irq_ctrl     (bus.irq_ctrl),
    .control_next (ctrl_sel)
  );

  assign bus.control_next = ctrl_sel;
  assign bus.state        = state_q;
  assign bus.step         = step_q;
  assign bus.cb_prefix_o  = cb_q;
  assign bus.illegal_o    = ill_q;
  assign bus.instr_done   = done_c & ~reset;
  assign bus.irq_ack      = ack_c & ~reset;

endmodule

// File: tb/tb_gb_cpu_mcycle_sequencer.sv
// Cycle-by-cycle vector bench for the M-cycle sequencer with a queue of expected outputs.
module tb_gb_cpu_mcycle_sequencer;
  import gb_cpu_common_pkg::*;

  localparam int unsigned MS = 6;
  localparam int unsigned CW = 64;
  localparam int unsigned IS = 5;
  localparam logic [CW-1:0] FCTRL = SEQ_FETCH_CTRL;
  localparam logic [CW-1:0] ICTRL = SEQ_IDLE_CTRL;
  localparam logic [1:0] SF = 2'd0, SE = 2'd1, SH = 2'd2, SI = 2'd3;

  typedef struct {
    int         idx;
    logic       rst;
    logic [2:0] len;
    logic       cb, halt, cond, stall, pend, ime;
    logic [1:0] e_state;
    logic [2:0] e_step;
    logic       e_done, e_ack, e_cb, e_ill;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  vec_t expq[$];

  gb_cpu_mcycle_sequencer_if #(.MAX_STEPS(MS), .CTRL_W(CW), .IRQ_STEPS(IS)) bus ();

  gb_cpu_mcycle_sequencer #(
    .MAX_STEPS(MS), .CTRL_W(CW), .IRQ_STEPS(IS), .FETCH_CTRL(FCTRL), .IDLE_CTRL(ICTRL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sched_word(logic [2:0] k);
    return 64'h5C00_0000_0000_0010 + 64'(k);
  endfunction

  function automatic logic [CW-1:0] irq_word(logic [2:0] k);
    return 64'h1A00_0000_0000_0020 + 64'(k);
  endfunction

  function automatic logic [CW-1:0] exp_ctrl(logic rst, logic [1:0] st, logic [2:0] stp);
    if (rst) return FCTRL;
    case (st)
      SF:      return FCTRL;
      SE:      return sched_word(stp);
      SH:      return ICTRL;
      default: return irq_word(stp);
    endcase
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(logic rst, logic [2:0] len, logic cb, logic halt, logic cond, logic stall,
                     logic pend, logic ime, logic [1:0] est, logic [2:0] estep,
                     logic edone, logic eack, logic ecb, logic eill);
    vec_t v;
    v.idx = vecs.size();
    v.rst = rst; v.len = len; v.cb = cb; v.halt = halt; v.cond = cond;
    v.stall = stall; v.pend = pend; v.ime = ime;
    v.e_state = est; v.e_step = estep; v.e_done = edone; v.e_ack = eack;
    v.e_cb = ecb; v.e_ill = eill;
    vecs.push_back(v);
  endtask

  // Pop the expectation for this cycle and compare mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      vec_t e;
      e = expq.pop_front();
      check("state",        e.idx, 64'(bus.state),        64'(e.e_state));
      check("step",         e.idx, 64'(bus.step),         64'(e.e_step));
      check("control_next", e.idx, bus.control_next,      exp_ctrl(e.rst, e.e_state, e.e_step));
      check("instr_done",   e.idx, 64'(bus.instr_done),   64'(e.e_done));
      check("irq_ack",      e.idx, 64'(bus.irq_ack),      64'(e.e_ack));
      check("cb_prefix_o",  e.idx, 64'(bus.cb_prefix_o),  64'(e.e_cb));
      check("illegal_o",    e.idx, 64'(bus.illegal_o),    64'(e.e_ill));
    end
  end

  initial begin
    for (int k = 0; k < int'(MS); k++) bus.sched_ctrl[k*CW +: CW] = sched_word(3'(k));
    for (int k = 0; k < int'(IS); k++) bus.irq_ctrl[k*CW +: CW] = irq_word(3'(k));
    reset = 1'b1;
    bus.sched_len = '0; bus.sched_cb_prefix = 1'b0; bus.sched_halt = 1'b0;
    bus.cond_not_met = 1'b0; bus.stall = 1'b0; bus.irq_pending = 1'b0; bus.ime = 1'b0;

    //    rst len cb ht cn st pd im | state step dn ak cb il
    add(1, 1, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    // NOP
    add(0, 1, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, SE, 0, 1, 0, 0, 0);
    // CALL, condition passes (len 5)
    add(0, 5, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    for (int s = 0; s < 5; s++) add(0, 5, 0, 0, 0, 0, 0, 0, SE, 3'(s), (s == 4), 0, 0, 0);
    // CALL, condition fails at step 2
    add(0, 5, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0, 0, 0, 0, 0, SE, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0, 0, 0, 0, 0, SE, 1, 0, 0, 0, 0);
    add(0, 5, 0, 0, 1, 0, 0, 0, SE, 2, 1, 0, 0, 0);
    // len 3 with a 3-cycle stall at step 1
    add(0, 3, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0, SE, 0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) add(0, 3, 0, 0, 0, 1, 0, 0, SE, 1, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0, SE, 1, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0, SE, 2, 1, 0, 0, 0);
    // CB prefix blocks dispatch; IRQ follows the CB-page opcode
    add(0, 1, 1, 0, 0, 0, 1, 1, SF, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 1, SE, 0, 1, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 1, 1, SF, 0, 0, 0, 1, 0);
    add(0, 2, 0, 0, 0, 0, 1, 1, SE, 0, 0, 0, 1, 0);
    add(0, 2, 0, 0, 0, 0, 1, 1, SE, 1, 1, 0, 1, 0);
    for (int s = 0; s < 5; s++) add(0, 1, 0, 0, 0, 0, 1, 1, SI, 3'(s), (s == 4), (s == 0), 0, 0);
    // HALT with ime=1, wake 4 cycles later into dispatch
    add(0, 1, 0, 1, 0, 0, 0, 1, SF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 1, SE, 0, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) add(0, 1, 0, 0, 0, 0, 0, 1, SH, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1, SH, 0, 0, 0, 0, 0);
    for (int s = 0; s < 5; s++) add(0, 1, 0, 0, 0, 0, 0, 1, SI, 3'(s), (s == 4), (s == 0), 0, 0);
    // HALT with ime=0 and irq already pending: one HALT cycle, then fetch
    add(0, 1, 0, 1, 0, 0, 1, 0, SF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, SE, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, SH, 0, 0, 0, 0, 0);
    // Dispatch with a stall on the first IRQ cycle
    add(0, 1, 0, 0, 0, 0, 1, 1, SF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1, SE, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 1, SI, 0, 0, 0, 0, 0);
    for (int s = 0; s < 5; s++) add(0, 1, 0, 0, 0, 0, 1, 1, SI, 3'(s), (s == 4), (s == 0), 0, 0);
    // CB prefix then reset at EXEC step 3
    add(0, 1, 1, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, SE, 0, 1, 0, 0, 0);
    add(0, 5, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 1, 0);
    for (int s = 0; s < 3; s++) add(0, 5, 0, 0, 0, 0, 0, 0, SE, 3'(s), 0, 0, 1, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0, SE, 3, 0, 0, 1, 0);
    // Illegal lengths 0 and 7
    add(0, 0, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, SE, 0, 1, 0, 0, 0);
    add(0, 7, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 1);
    add(0, 7, 0, 0, 0, 0, 0, 0, SE, 0, 1, 0, 0, 1);
    // Reset mid-dispatch clears illegal_o and abandons the sequence
    add(0, 1, 0, 0, 0, 0, 1, 1, SF, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1, SE, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1, SI, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 1, SI, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, SE, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, SF, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset               = vecs[i].rst;
      bus.sched_len       = vecs[i].len;
      bus.sched_cb_prefix = vecs[i].cb;
      bus.sched_halt      = vecs[i].halt;
      bus.cond_not_met    = vecs[i].cond;
      bus.stall           = vecs[i].stall;
      bus.irq_pending     = vecs[i].pend;
      bus.ime             = vecs[i].ime;
      expq.push_back(vecs[i]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", vecs.size(), 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
